// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state, control-bit and width constants for pipe_skid_reg
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEM2REG  = 3;

    localparam int DEF_CTRL_W   = 4;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_DATA = 2;
    localparam int DEF_ADDR_W   = 5;

    // SKID is only ever occupied while MAIN is, so the two valid bits fully encode the state
    function automatic pipe_state_e stateOf(input logic mainValid, input logic skidValid);
        if (skidValid)
            return FULL;
        else if (mainValid)
            return ONE;
        else
            return EMPTY;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - valid flag plus payload register used for the MAIN and SKID slots
module pipe_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         validNext,
    input  logic         loadEn,
    input  logic [W-1:0] payloadNext,
    output logic         valid,
    output logic [W-1:0] payload
);

    // valid follows validNext every cycle; payload only moves on load so it holds after a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            payload <= '0;
        end else begin
            valid <= validNext;
            if (loadEn)
                payload <= payloadNext;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic stage register with two-entry skid and flush; PIPE_SKID_STATS_EN adds stall_cnt
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_DATA = DEF_NUM_DATA,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0]          in_rd,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]          out_rd
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int DW = NUM_DATA * DATA_W;
    localparam int PW = CTRL_W + DW + ADDR_W;

    logic          mainValid, skidValid;
    logic [PW-1:0] mainPayload, skidPayload, inPayload, mainPayloadNext;
    logic          mainValidNext, skidValidNext;
    logic          mainLoad, skidLoad, mainFromSkid;
    logic          acceptIn, retireOut;
    pipe_state_e   curState;

    assign curState  = stateOf(mainValid, skidValid);
    assign in_ready  = (curState != FULL);
    assign out_valid = mainValid;
    assign acceptIn  = in_valid && in_ready;
    assign retireOut = out_valid && out_ready;
    assign inPayload = {in_ctrl, in_data, in_rd};

    always_comb begin
        mainValidNext = mainValid;
        skidValidNext = skidValid;
        mainLoad      = 1'b0;
        skidLoad      = 1'b0;
        mainFromSkid  = 1'b0;
        if (flush) begin
            mainValidNext = 1'b0;
            skidValidNext = 1'b0;
        end else begin
            case (curState)
                EMPTY: begin
                    if (acceptIn) begin
                        mainLoad      = 1'b1;
                        mainValidNext = 1'b1;
                    end
                end
                ONE: begin
                    if (acceptIn && retireOut) begin
                        mainLoad = 1'b1;
                    end else if (acceptIn) begin
                        skidLoad      = 1'b1;
                        skidValidNext = 1'b1;
                    end else if (retireOut) begin
                        mainValidNext = 1'b0;
                    end
                end
                FULL: begin
                    if (retireOut) begin
                        mainLoad      = 1'b1;
                        mainFromSkid  = 1'b1;
                        skidValidNext = 1'b0;
                    end
                end
                default: begin
                    mainValidNext = 1'b0;
                    skidValidNext = 1'b0;
                end
            endcase
        end
    end

    assign mainPayloadNext = mainFromSkid ? skidPayload : inPayload;

    pipe_entry #(.W(PW)) u_main (
        .clk         (clk),
        .rst_n       (rst_n),
        .validNext   (mainValidNext),
        .loadEn      (mainLoad),
        .payloadNext (mainPayloadNext),
        .valid       (mainValid),
        .payload     (mainPayload)
    );

    pipe_entry #(.W(PW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .validNext   (skidValidNext),
        .loadEn      (skidLoad),
        .payloadNext (inPayload),
        .valid       (skidValid),
        .payload     (skidPayload)
    );

    // control is gated so a bubble can never assert RegWrite/MemRead/MemWrite downstream
    assign out_ctrl = mainValid ? mainPayload[PW-1 -: CTRL_W] : '0;
    assign out_data = mainPayload[ADDR_W +: DW];
    assign out_rd   = mainPayload[ADDR_W-1:0];

`ifdef PIPE_SKID_STATS_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stallCnt <= '0;
        else if (flush)
            stallCnt <= '0;
        else if (out_valid && !out_ready && (stallCnt != 32'hFFFF_FFFF))
            stallCnt <= stallCnt + 32'd1;
    end

    assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and random checks of pipe_skid_reg against a queue model
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [3:0]  in_ctrl, out_ctrl;
    logic [63:0] in_data, out_data;
    logic [4:0]  in_rd, out_rd;
    logic [31:0] stall_cnt;

    logic         wIn_valid, wIn_ready, wOut_valid, wOut_ready, wFlush;
    logic [5:0]   wIn_ctrl, wOut_ctrl, wIn_rd, wOut_rd;
    logic [191:0] wIn_data, wOut_data;
    logic [31:0]  wStall;

    pipe_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_rd(out_rd)
`ifdef PIPE_SKID_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipe_skid_reg #(.CTRL_W(6), .DATA_W(64), .NUM_DATA(3), .ADDR_W(6)) dutWide (
        .clk(clk), .rst_n(rst_n), .in_valid(wIn_valid), .in_ready(wIn_ready),
        .in_ctrl(wIn_ctrl), .in_data(wIn_data), .in_rd(wIn_rd), .flush(wFlush),
        .out_valid(wOut_valid), .out_ready(wOut_ready), .out_ctrl(wOut_ctrl),
        .out_data(wOut_data), .out_rd(wOut_rd)
`ifdef PIPE_SKID_STATS_EN
        , .stall_cnt(wStall)
`endif
    );

`ifndef PIPE_SKID_STATS_EN
    assign stall_cnt = 32'd0;
    assign wStall    = 32'd0;
`endif

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] data;
        logic [4:0]  rd;
    } beat_t;

    beat_t       q[$];
    beat_t       lastB;
    logic [31:0] stallM;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        q.delete();
        lastB  = '{4'h0, 64'h0, 5'h0};
        stallM = 32'd0;
    endtask

    task automatic checkAll();
        beat_t e;
        e = (q.size() > 0) ? q[0] : lastB;
        chk("out_valid", 256'(out_valid), 256'(q.size() > 0));
        chk("in_ready", 256'(in_ready), 256'(q.size() < 2));
        chk("out_ctrl", 256'(out_ctrl), 256'((q.size() > 0) ? e.ctrl : 4'h0));
        chk("out_data", 256'(out_data), 256'(e.data));
        chk("out_rd", 256'(out_rd), 256'(e.rd));
`ifdef PIPE_SKID_STATS_EN
        chk("stall_cnt", 256'(stall_cnt), 256'(stallM));
`endif
    endtask

    // advance one clock: update the model from the pre-edge occupancy, then compare at the falling edge
    task automatic tick();
        bit ovM, irM;
        @(posedge clk);
        ovM = (q.size() > 0);
        irM = (q.size() < 2);
        if (flush)
            stallM = 32'd0;
        else if (ovM && !out_ready && stallM != 32'hFFFF_FFFF)
            stallM = stallM + 32'd1;
        if (flush) begin
            q.delete();
        end else begin
            if (ovM && out_ready)
                void'(q.pop_front());
            if (in_valid && irM)
                q.push_back('{in_ctrl, in_data, in_rd});
        end
        if (q.size() > 0)
            lastB = q[0];
        @(negedge clk);
        checkAll();
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic ordy);
        in_valid  = v;
        in_ctrl   = 4'($urandom);
        in_data   = {$urandom, $urandom};
        in_rd     = rd;
        out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; in_rd = '0;
        flush = 1'b0; out_ready = 1'b0;
        wIn_valid = 1'b0; wIn_ctrl = '0; wIn_data = '0; wIn_rd = '0;
        wOut_ready = 1'b1; wFlush = 1'b0;
        resetModel();
        #2;
        chk("reset_state", 256'({out_valid, in_ready, out_ctrl, out_data, out_rd}),
            256'({1'b0, 1'b1, 4'h0, 64'h0, 5'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        checkAll();

        // streaming: 8 beats back-to-back, each visible one cycle after acceptance
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i), 1'b1);
            in_data = {32'h0, 32'h10 + 32'(i)};
            tick();
            chk("stream_word0", 256'(out_data[31:0]), 256'(32'h10 + 32'(i)));
            chk("stream_valid", 256'(out_valid), 256'(1'b1));
        end

        // back-pressure for three cycles in the middle of a stream
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(8 + i), !(i >= 2 && i <= 4));
            tick();
            if (i == 3)
                chk("bp_in_ready", 256'(in_ready), 256'(1'b0));
        end
`ifdef PIPE_SKID_STATS_EN
        chk("bp_stall_cnt", 256'(stall_cnt), 256'(32'd3));
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b1);
            tick();
        end

        // flush from FULL with a new beat offered in the same cycle
        drive(1'b1, 5'd5, 1'b0); tick();
        drive(1'b1, 5'd6, 1'b0); tick();
        chk("flush_full", 256'(in_ready), 256'(1'b0));
        drive(1'b1, 5'd7, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 256'(out_valid), 256'(1'b0));
        chk("flush_ctrl", 256'(out_ctrl), 256'(4'h0));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b1);
            tick();
            chk("flush_no_reappear", 256'(out_valid), 256'(1'b0));
        end

        // bubble: control on the input bus must not leak when nothing is valid
        drive(1'b0, 5'd9, 1'b1);
        in_ctrl = 4'hF;
        tick();
        chk("bubble_ctrl", 256'(out_ctrl), 256'(4'h0));

        // asynchronous reset while FULL
        drive(1'b1, 5'd1, 1'b0); tick();
        drive(1'b1, 5'd2, 1'b0); tick();
        rst_n = 1'b0;
        resetModel();
        #1;
        chk("async_rst", 256'({out_valid, in_ready, out_ctrl, stall_cnt}),
            256'({1'b0, 1'b1, 4'h0, 32'd0}));
        #2;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 1'b1);
        tick();

        // wide configuration: third data word must pass intact
        wIn_valid = 1'b1;
        wIn_ctrl  = 6'h2A;
        wIn_rd    = 6'h21;
        wIn_data  = {64'hDEAD_BEEF_0000_0001, 64'h2222_0000_0000_0002, 64'h3333_0000_0000_0003};
        tick();
        chk("wide_valid", 256'(wOut_valid), 256'(1'b1));
        chk("wide_word2", 256'(wOut_data[191:128]), 256'(64'hDEAD_BEEF_0000_0001));
        chk("wide_word0", 256'(wOut_data[63:0]), 256'(64'h3333_0000_0000_0003));
        chk("wide_ctrl_rd", 256'({wOut_ctrl, wOut_rd}), 256'({6'h2A, 6'h21}));
        wIn_valid = 1'b0;
        tick();
        chk("wide_bubble", 256'({wOut_valid, wOut_ctrl, wIn_ready}), 256'({1'b0, 6'h0, 1'b1}));
        chk("wide_hold", 256'(wOut_data[191:128]), 256'(64'hDEAD_BEEF_0000_0001));
        chk("wide_stall", 256'(wStall), 256'(32'd0));

        // random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), 5'($urandom), ($urandom_range(0, 9) < 6));
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register for stage boundaries (EX/MEM first, then ID/EX and MEM/WB). Carries a control bundle, NUM_DATA data words and a destination register address from producer to consumer under a valid/ready handshake, with a two-entry skid buffer so back-pressure never drops or duplicates a beat. Adds synchronous flush (bubble insertion), which hazard logic uses on branch mispredict.

## Interface
- CTRL_W, default 4: control bits; bit order {Mem2Reg, MemWrite, MemRead, RegWrite}, bit 0 = RegWrite.
- DATA_W, default 32: width of each data word.
- NUM_DATA, default 2: data words per beat; word 0 = ALU result, word 1 = Rt data.
- ADDR_W, default 5: destination register address width.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  NUM_DATA*DATA_W  data words, word 0 in LSBs.
- in_rd  in  ADDR_W  destination register.
- flush  in  1  discard all held beats and the current input beat.
- out_valid  out  1  beat presented to consumer.
- out_ready  in  1  consumer accepts the beat.
- out_ctrl  out  CTRL_W  control; forced to 0 whenever out_valid=0.
- out_data  out  NUM_DATA*DATA_W  data words.
- out_rd  out  ADDR_W  destination register.

## Operation
- Two entries: MAIN (drives outputs) and SKID. States: EMPTY (none valid), ONE (MAIN valid), FULL (MAIN and SKID valid).
- Input handshake: beat accepted when in_valid && in_ready. Output handshake: beat retired when out_valid && out_ready.
- in_ready = (state != FULL); registered-state derived, no combinational path from out_ready.
- Transitions (no flush):
  - EMPTY: accept -> ONE (MAIN <= input).
  - ONE: accept & retire -> ONE (MAIN <= input); accept only -> FULL (SKID <= input); retire only -> EMPTY.
  - FULL: retire -> ONE (MAIN <= SKID); no accept possible.
- Beat order strictly preserved; each accepted beat appears on outputs exactly once.
- flush=1: next state EMPTY regardless of state, handshakes or in_valid; input beat that cycle is dropped even if in_ready=1. in_ready stays as computed (producer sees accept, beat is discarded by design).
- out_ctrl = MAIN.ctrl when out_valid else 0 (bubble: no RegWrite/MemRead/MemWrite leaks). out_data/out_rd hold last MAIN contents when invalid.
- Reset: state EMPTY; out_valid=0, in_ready=1, out_ctrl=0, out_data=0, out_rd=0; SKID contents 0. Reset asserted mid-operation discards all beats immediately (asynchronous).

## Timing
- Latency 1 cycle: beat accepted at edge N is on outputs after edge N, with out_valid=1, when MAIN was empty or retiring.
- Throughput 1 beat/cycle with out_ready held high.
- out_ready low for one cycle while streaming: the next input beat lands in SKID, in_ready drops for exactly the following cycle, no bubble on output once out_ready returns.
- flush takes effect at the next edge; outputs show out_valid=0 the cycle after flush.
- Simultaneous flush and retire: retire counts on consumer side, nothing else remains.

## Configuration
- PIPE_SKID_STATS_EN defined: adds output stall_cnt [31:0], counting cycles with out_valid && !out_ready, saturating at 32'hFFFF_FFFF, reset to 0, cleared by flush. Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package pipe_pkg: state enum (EMPTY, ONE, FULL), control bit index constants (CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_MEM2REG=3), default width constants.
- One sub-module: pipe_entry, a parametrised valid+payload holding register with async active-low reset and load enable, instantiated for MAIN and SKID.

## Test plan
- Reset: rst_n=0 mid-stream with FULL -> out_valid=0, in_ready=1, out_ctrl=0 immediately, stall_cnt=0.
- Streaming: 8 beats, ALU result 32'h10..32'h17, out_ready=1 -> outputs identical, in order, one cycle later, no bubbles.
- Back-pressure: out_ready=0 for 3 cycles mid-stream -> FULL reached, in_ready=0, no beat lost/duplicated; stall_cnt=3.
- Flush: FULL state with beats rd=5,6, flush=1 with in_valid=1 rd=7 -> next cycle out_valid=0, out_ctrl=4'b0000; rd=5/6/7 never reappear.
- Bubble: in_ctrl=4'b1111 with in_valid=0 -> out_ctrl stays 4'b0000.
- Width: CTRL_W=6, DATA_W=64, NUM_DATA=3, ADDR_W=6 -> word 2 (64'hDEAD_BEEF_0000_0001) passes intact.
